// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Sequences a wide add through an external 4-bit adder, one
//               nibble per cycle LSB first. SERIAL_ADD_SUB_EN adds subtract.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                   in_sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout
);

  localparam int c_W  = 4 * NIBBLES;
  localparam int c_IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_W-1:0]  a_q, a_d;
  logic [c_W-1:0]  b_q, b_d;
  logic [c_W-1:0]  res_q, res_d;
  logic            carry_q, carry_d;
  logic [c_IW-1:0] idx_q, idx_d;
  logic [c_W-1:0]  w_res_shift;
`ifdef SERIAL_ADD_SUB_EN
  logic            sub_q, sub_d;
`endif

  // Each returned sum nibble enters at the top, so after NIBBLES shifts the
  // first (least-significant) nibble has reached bit 0.
  generate
    if (NIBBLES == 1) begin : g_single
      assign w_res_shift = add_sum;
    end else begin : g_multi
      assign w_res_shift = {add_sum, res_q[c_W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          idx_d   = '0;
          state_d = c_RUN;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = in_sub;
          carry_d = in_sub ? 1'b1 : in_cin;
`else
          carry_d = in_cin;
`endif
        end
      end
      c_RUN: begin
        res_d   = w_res_shift;
        carry_d = add_cout;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        idx_d   = idx_q + c_IW'(1);
        if (idx_q == c_IW'(NIBBLES - 1)) begin
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        if (out_ready) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == c_IDLE);
    out_valid = (state_q == c_DONE);
    out_sum   = (state_q == c_DONE) ? res_q : '0;
    out_cout  = (state_q == c_DONE) ? carry_q : 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    if (state_q == c_RUN) begin
      add_a   = a_q[3:0];
      add_cin = carry_q;
`ifdef SERIAL_ADD_SUB_EN
      add_b   = sub_q ? ~b_q[3:0] : b_q[3:0];
`else
      add_b   = b_q[3:0];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Scoreboard bench for nibble_serial_add_ctrl with an
//               arithmetic reference model and a behavioural 4-bit adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         in_sub;
`endif
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int total = 0;
  int bad   = 0;
  bit bp_rand = 1'b0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub   (in_sub),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_note("accept_wait");
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
    in_sub   = sub;
`endif
    @(posedge clk);
    exp_q.push_back(model(a, b, cin, sub));
    #1 in_valid = 1'b0;
  endtask

  // Checks the nibble stream presented to the adder and the exact latency.
  task automatic run_traced(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    longint m;
    longint ec;
    do_op(a, b, cin, 1'b0);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      m  = longint'(1) << (4 * k);
      ec = ((longint'(a) % m) + (longint'(b) % m) + longint'(cin)) >> (4 * k);
      chk($sformatf("add_a[%0d]", k), 64'(add_a), 64'((a >> (4 * k)) & 16'hF));
      chk($sformatf("add_b[%0d]", k), 64'(add_b), 64'((b >> (4 * k)) & 16'hF));
      chk($sformatf("add_cin[%0d]", k), 64'(add_cin), 64'(ec));
      chk($sformatf("early_valid[%0d]", k), 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    chk("latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: a result is consumed on any cycle it is handshaken.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h want none", out_sum);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result_sum", 64'(out_sum), 64'(e[W-1:0]));
        chk("result_cout", 64'(out_cout), 64'(e[W]));
      end
    end
  end

  always @(posedge clk) begin
    if (bp_rand) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [W:0] held;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    in_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_cin, out_cout}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_traced(16'h1234, 16'h1111, 1'b0);
    run_traced(16'hFFFF, 16'h0001, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    held = model(16'hABCD, 16'h1234, 1'b0, 1'b0);
    do_op(16'hABCD, 16'h1234, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) fail_note("bp_valid_wait");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 16'h5A5A; in_b = 16'h0F0F;
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(out_sum), 64'(held[W-1:0]));
      chk("bp_cout", 64'(out_cout), 64'(held[W]));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_valid", 64'(out_valid), 64'd0);

    // Abort two cycles into RUN.
    @(posedge clk); #1;
    do_op(16'h5555, 16'h2222, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_outs", 64'({out_sum, out_cout, add_a, add_b, add_cin}), 64'd0);
    @(posedge clk); #1;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1);
`endif

    bp_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic sub;
      sub = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub = $urandom_range(0, 1) != 0;
`endif
      do_op(W'($urandom), W'($urandom), $urandom_range(0, 1) != 0, sub);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    @(posedge clk);
    bp_rand = 1'b0;
    #1 out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
